pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised N-stage pipeline register chain for the Y86-64 pipelined core; it replaces hand-wired per-stage register instances between fetch and write-back. Each stage carries a valid bit, a 2-bit status and a WIDTH-bit payload, and honours per-stage stall and bubble controls driven by the pipeline control logic. On top of plain staging it adds automatic bubble insertion behind a stalled stage, a halt state machine that freezes the whole chain when an exception status retires, and saturating performance counters.

## Interface
- STAGES, 4: number of register stages (D, E, M, W); legal ≥ 2.
- WIDTH, 64: payload width per stage.
- BUBBLE_VAL, 0: payload loaded on a bubble (nop encoding), WIDTH bits.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is offered to stage 0.
- in_stat  in  2  status of the offered instruction.
- in_data  in  WIDTH  payload of the offered instruction.
- stall  in  STAGES  per-stage hold; bit i controls stage i (0 = nearest input).
- bubble  in  STAGES  per-stage bubble injection.
- clr_cnt  in  1  synchronous clear of all counters.
- stage_valid  out  STAGES  valid bit of each stage.
- stage_stat  out  2*STAGES  flattened status; stage i at [2i+1:2i].
- stage_data  out  WIDTH*STAGES  flattened payload; stage i at [WIDTH*i +: WIDTH].
- out_valid / out_stat / out_data  out  1/2/WIDTH  copy of last stage (STAGES-1).
- halted  out  1  chain frozen after exception retire.
- halt_stat  out  2  status that caused the halt.
- cnt_cycle, cnt_retire, cnt_bubble  out  CNT_W each  performance counters.

## Operation
- Status codes: SAOK=0, SHLT=1, SADR=2, SINS=3.
- Stage i source: stage i-1 outputs; for stage 0, in_* (in_valid=0 acts as a bubble source).
- Per-stage next-state priority, highest first:
  - state HALT: hold.
  - stall[i]=1: hold (stall beats bubble when both are set).
  - bubble[i]=1, or (i>0 and stall[i-1]=1): load bubble = valid 0, stat SAOK, data BUBBLE_VAL. The auto-bubble prevents duplicating an instruction held upstream.
  - otherwise: load source.
- Halt FSM, two states:
  - RUN → HALT at an edge where out_valid=1, out_stat≠SAOK and stall[STAGES-1]=0; halt_stat latches out_stat at that edge.
  - HALT is left only by reset. The faulting instruction remains visible on out_*.
- Counters (all saturate at 2^CNT_W-1; clr_cnt beats increment and clears in RUN or HALT):
  - cnt_cycle: +1 every edge in RUN.
  - cnt_retire: +1 at an edge in RUN with out_valid=1, out_stat=SAOK, stall[STAGES-1]=0.
  - cnt_bubble: +1 at an edge in RUN with out_valid=0, stall[STAGES-1]=0.

## Timing
- Reset (asynchronous, immediate): stage_valid=0, all stat=SAOK, all data=BUBBLE_VAL, halted=0, halt_stat=SAOK, all counters=0, state RUN.
- Latency in→out: STAGES edges with no stall or bubble. Throughput 1 per cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- halted rises in the cycle after the retiring edge of the faulting instruction. stall and bubble are ignored from then on.
- Deassertion of rst_n takes effect at the first clk edge after release.

## Structure
- Shared package y86_pkg: stat constants SAOK/SHLT/SADR/SINS, halt FSM enum {RUN, HALT}.
- Sub-module pipe_stage: one register stage (valid/stat/data, hold/bubble/load mux, async reset). Instantiated STAGES times via generate.
- Top pipe_chain holds the auto-bubble wiring, the halt FSM and the counters.

## Test plan
- Flow: STAGES=4, inject payloads 1,2,3,4 valid SAOK on consecutive edges, no stalls → out_data=1 four edges after the first inject, then 2,3,4 on successive cycles; cnt_retire=4.
- Stall: payload 0xA in stage 1, stall=4'b0011 for one edge → stages 0 and 1 hold, stage 2 becomes bubble (valid 0, data 0); after release 0xA reaches out one cycle late and cnt_bubble=1.
- Bubble priority: bubble[2]=1 and stall[2]=1 together → stage 2 holds; bubble[2]=1 alone → stage 2 loads valid 0, data BUBBLE_VAL.
- Halt: inject SAOK, SADR, SAOK → SADR retires, next cycle halted=1 and halt_stat=2; further inputs and stall/bubble leave all stages unchanged; cnt_retire stays 1 and cnt_cycle stops.
- Reset mid-run: drop rst_n asynchronously mid-cycle while halted with counters nonzero → all outputs take reset values immediately, before the next edge.
- Saturation/clear: CNT_W=4, run 20 edges → cnt_cycle=15; assert clr_cnt on an incrementing edge → cnt_cycle=0 next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions:
// status codes and halt FSM states.
package y86_pkg;

   typedef logic [1:0] stat_t;

   localparam stat_t SAOK = 2'd0;
   localparam stat_t SHLT = 2'd1;
   localparam stat_t SADR = 2'd2;
   localparam stat_t SINS = 2'd3;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } halt_st_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: valid, status and payload
// with hold / bubble / load selection.
module pipe_stage
   import y86_pkg::*;
#(
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_hold,
   input  logic             i_bubble,
   input  logic             i_valid,
   input  stat_t            i_stat,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output stat_t            o_stat,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   stat_t            r_stat;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_stat  <= SAOK;
         r_data  <= BUBBLE_VAL;
      end else if (!i_hold) begin
         if (i_bubble) begin
            r_valid <= 1'b0;
            r_stat  <= SAOK;
            r_data  <= BUBBLE_VAL;
         end else begin
            r_valid <= i_valid;
            r_stat  <= i_stat;
            r_data  <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_stat  = r_stat;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_chain.sv
// N-stage Y86-64 pipeline register chain with auto-bubble,
// halt-on-exception freeze and saturating perf counters.
module pipe_chain
   import y86_pkg::*;
#(
   parameter int                 STAGES     = 4,
   parameter int                 WIDTH      = 64,
   parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0,
   parameter int                 CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [1:0]                in_stat,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         bubble,
   input  logic                      clr_cnt,
   output logic [STAGES-1:0]         stage_valid,
   output logic [2*STAGES-1:0]       stage_stat,
   output logic [WIDTH*STAGES-1:0]   stage_data,
   output logic                      out_valid,
   output logic [1:0]                out_stat,
   output logic [WIDTH-1:0]          out_data,
   output logic                      halted,
   output logic [1:0]                halt_stat,
   output logic [CNT_W-1:0]          cnt_cycle,
   output logic [CNT_W-1:0]          cnt_retire,
   output logic [CNT_W-1:0]          cnt_bubble
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   halt_st_t r_state;
   halt_st_t w_next_state;
   stat_t    r_halt_stat;
   stat_t    w_next_hstat;

   logic [CNT_W-1:0] r_cnt_cycle;
   logic [CNT_W-1:0] r_cnt_retire;
   logic [CNT_W-1:0] r_cnt_bubble;

   logic             w_run;
   logic             w_fault;
   logic             w_retire;
   logic             w_idle;
   logic             w_freeze;

   logic [STAGES-1:0] w_hold;
   logic [STAGES-1:0] w_bub;
   logic [STAGES-1:0] w_src_valid;
   stat_t             w_src_stat [STAGES];
   logic [WIDTH-1:0]  w_src_data [STAGES];
   logic [STAGES-1:0] w_q_valid;
   stat_t             w_q_stat [STAGES];
   logic [WIDTH-1:0]  w_q_data [STAGES];

   assign w_run    = (r_state == RUN);
   assign w_fault  = w_run & out_valid & (out_stat != SAOK)
                   & ~stall[STAGES-1];
   assign w_retire = out_valid & (out_stat == SAOK)
                   & ~stall[STAGES-1];
   assign w_idle   = ~out_valid & ~stall[STAGES-1];

   // Freezing on the fault edge keeps the faulting instruction on out_*.
   assign w_freeze = ~w_run | w_fault;
   assign w_hold   = stall | {STAGES{w_freeze}};

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign w_src_valid[g] = in_valid;
         assign w_src_stat[g]  = in_valid ? in_stat : SAOK;
         assign w_src_data[g]  = in_valid ? in_data : BUBBLE_VAL;
         assign w_bub[g]       = bubble[g];
      end else begin : g_body
         assign w_src_valid[g] = w_q_valid[g-1];
         assign w_src_stat[g]  = w_q_stat[g-1];
         assign w_src_data[g]  = w_q_data[g-1];
         // Upstream stall leaves a hole rather than a duplicate.
         assign w_bub[g]       = bubble[g] | stall[g-1];
      end

      pipe_stage #(
         .WIDTH      (WIDTH),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_hold   (w_hold[g]),
         .i_bubble (w_bub[g]),
         .i_valid  (w_src_valid[g]),
         .i_stat   (w_src_stat[g]),
         .i_data   (w_src_data[g]),
         .o_valid  (w_q_valid[g]),
         .o_stat   (w_q_stat[g]),
         .o_data   (w_q_data[g])
      );

      assign stage_valid[g]             = w_q_valid[g];
      assign stage_stat[2*g +: 2]       = w_q_stat[g];
      assign stage_data[WIDTH*g +: WIDTH] = w_q_data[g];
   end

   assign out_valid = w_q_valid[STAGES-1];
   assign out_stat  = w_q_stat[STAGES-1];
   assign out_data  = w_q_data[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_halt_stat <= SAOK;
      end else begin
         r_state     <= w_next_state;
         r_halt_stat <= w_next_hstat;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_hstat = r_halt_stat;
      unique case (r_state)
         RUN: begin
            if (w_fault) begin
               w_next_state = HALT;
               w_next_hstat = out_stat;
            end
         end
         HALT: begin
            w_next_state = HALT;
         end
      endcase
   end

   assign halted    = (r_state == HALT);
   assign halt_stat = r_halt_stat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_cycle  <= '0;
         r_cnt_retire <= '0;
         r_cnt_bubble <= '0;
      end else if (clr_cnt) begin
         r_cnt_cycle  <= '0;
         r_cnt_retire <= '0;
         r_cnt_bubble <= '0;
      end else if (w_run) begin
         if (r_cnt_cycle != CNT_MAX)
            r_cnt_cycle <= r_cnt_cycle + 1'b1;
         if (w_retire && r_cnt_retire != CNT_MAX)
            r_cnt_retire <= r_cnt_retire + 1'b1;
         if (w_idle && r_cnt_bubble != CNT_MAX)
            r_cnt_bubble <= r_cnt_bubble + 1'b1;
      end
   end

   assign cnt_cycle  = r_cnt_cycle;
   assign cnt_retire = r_cnt_retire;
   assign cnt_bubble = r_cnt_bubble;

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: per-edge reference model
// feeds an expectation queue drained by a negedge monitor.
module tb_pipe_chain;
   import y86_pkg::*;

   localparam int S  = 4;
   localparam int W  = 16;
   localparam int CW = 5;
   localparam logic [W-1:0] BV = 16'h0B0B;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid;
   logic [1:0] in_stat;
   logic [W-1:0] in_data;
   logic [S-1:0] stall;
   logic [S-1:0] bubble;
   logic clr_cnt;
   logic [S-1:0] stage_valid;
   logic [2*S-1:0] stage_stat;
   logic [W*S-1:0] stage_data;
   logic out_valid;
   logic [1:0] out_stat;
   logic [W-1:0] out_data;
   logic halted;
   logic [1:0] halt_stat;
   logic [CW-1:0] cnt_cycle, cnt_retire, cnt_bubble;

   always #5 clk = ~clk;

   pipe_chain #(
      .STAGES(S), .WIDTH(W), .BUBBLE_VAL(BV), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_stat(in_stat), .in_data(in_data),
      .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
      .stage_valid(stage_valid), .stage_stat(stage_stat),
      .stage_data(stage_data),
      .out_valid(out_valid), .out_stat(out_stat), .out_data(out_data),
      .halted(halted), .halt_stat(halt_stat),
      .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire),
      .cnt_bubble(cnt_bubble)
   );

   typedef struct {
      logic [S-1:0]   v;
      logic [2*S-1:0] st;
      logic [W*S-1:0] d;
      logic           h;
      logic [1:0]     hs;
      logic [CW-1:0]  cc, cr, cb;
   } snap_t;

   snap_t q[$];
   int checks = 0;
   int errors = 0;

   // reference model: pipeline as plain arrays
   bit        mv [S];
   bit [1:0]  ms [S];
   bit [W-1:0] md [S];
   bit        mh;
   bit [1:0]  mhs;
   int        cc, cr, cb;

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %h required %h at %0t", n, a, e, $time);
      end
   endfunction

   function automatic snap_t snap();
      snap_t s;
      for (int i = 0; i < S; i++) begin
         s.v[i] = mv[i];
         s.st[2*i +: 2] = ms[i];
         s.d[W*i +: W] = md[i];
      end
      s.h = mh; s.hs = mhs;
      s.cc = CW'(cc); s.cr = CW'(cr); s.cb = CW'(cb);
      return s;
   endfunction

   function automatic void mreset();
      for (int i = 0; i < S; i++) begin
         mv[i] = 0; ms[i] = 0; md[i] = BV;
      end
      mh = 0; mhs = 0; cc = 0; cr = 0; cb = 0;
   endfunction

   function automatic void mstep();
      bit        ov [S];
      bit [1:0]  os [S];
      bit [W-1:0] od [S];
      bit last_v = mv[S-1];
      bit [1:0] last_s = ms[S-1];
      bit go = !stall[S-1];
      for (int i = 0; i < S; i++) begin
         ov[i] = mv[i]; os[i] = ms[i]; od[i] = md[i];
      end
      if (clr_cnt) begin
         cc = 0; cr = 0; cb = 0;
      end else if (!mh) begin
         if (cc < CMAX) cc++;
         if (go && last_v && last_s == SAOK && cr < CMAX) cr++;
         if (go && !last_v && cb < CMAX) cb++;
      end
      if (!mh) begin
         if (go && last_v && last_s != SAOK) begin
            mh = 1; mhs = last_s;
         end else begin
            for (int i = 0; i < S; i++) begin
               if (stall[i]) begin
               end else if (bubble[i] || (i > 0 && stall[i-1])) begin
                  mv[i] = 0; ms[i] = SAOK; md[i] = BV;
               end else if (i == 0) begin
                  mv[0] = in_valid;
                  ms[0] = in_valid ? in_stat : SAOK;
                  md[0] = in_valid ? in_data : BV;
               end else begin
                  mv[i] = ov[i-1]; ms[i] = os[i-1]; md[i] = od[i-1];
               end
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mreset();
         q.delete();
      end else begin
         mstep();
      end
      q.push_back(snap());
   end

   always @(negedge clk) begin
      if (q.size() > 0) begin
         snap_t e;
         e = q.pop_front();
         chk("sb_valid", 64'(stage_valid), 64'(e.v));
         chk("sb_stat", 64'(stage_stat), 64'(e.st));
         chk("sb_data", 64'(stage_data), 64'(e.d));
         chk("sb_halted", 64'(halted), 64'(e.h));
         chk("sb_hstat", 64'(halt_stat), 64'(e.hs));
         chk("sb_cycle", 64'(cnt_cycle), 64'(e.cc));
         chk("sb_retire", 64'(cnt_retire), 64'(e.cr));
         chk("sb_bubble", 64'(cnt_bubble), 64'(e.cb));
      end
   end

   task automatic drv(bit v, logic [1:0] s, logic [W-1:0] d,
                      logic [S-1:0] stl, logic [S-1:0] bub, bit clr);
      in_valid = v; in_stat = s; in_data = d;
      stall = stl; bubble = bub; clr_cnt = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) drv(0, SAOK, '0, '0, '0, 0);
   endtask

   task automatic chk_reset(string n);
      chk({n, "_valid"}, 64'(stage_valid), 64'(0));
      chk({n, "_data"}, 64'(stage_data), {BV, BV, BV, BV});
      chk({n, "_stat"}, 64'(stage_stat), 64'(0));
      chk({n, "_halted"}, 64'(halted), 64'(0));
      chk({n, "_hstat"}, 64'(halt_stat), 64'(0));
      chk({n, "_cyc"}, 64'(cnt_cycle), 64'(0));
      chk({n, "_ret"}, 64'(cnt_retire), 64'(0));
      chk({n, "_bub"}, 64'(cnt_bubble), 64'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      in_valid = 0; in_stat = 0; in_data = 0;
      stall = 0; bubble = 0; clr_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("init");
      rst_n = 1'b1;

      // flow: 1,2,3,4 back to back
      for (int k = 1; k <= 4; k++) drv(1, SAOK, W'(k), '0, '0, 0);
      chk("flow_out1", 64'(out_data), 64'(1));
      for (int k = 2; k <= 4; k++) begin
         idle(1);
         chk("flow_out", 64'(out_data), 64'(k));
         chk("flow_ov", 64'(out_valid), 64'(1));
      end
      idle(1);
      chk("flow_retire", 64'(cnt_retire), 64'(4));

      // stall stages 0 and 1 with 0xA in stage 1
      idle(3);
      drv(1, SAOK, 16'h000A, '0, '0, 0);
      idle(1);
      drv(0, SAOK, '0, 4'b0011, '0, 0);
      chk("stall_hold", 64'(stage_data[W*1 +: W]), 64'h000A);
      chk("stall_bv", 64'(stage_valid[2]), 64'(0));
      chk("stall_bd", 64'(stage_data[W*2 +: W]), 64'(BV));
      idle(1);
      chk("stall_late0", 64'(out_valid), 64'(0));
      idle(1);
      chk("stall_late", 64'(out_data), 64'h000A);

      // bubble vs stall priority on stage 2
      idle(3);
      drv(1, SAOK, 16'h000B, '0, '0, 0);
      idle(2);
      drv(0, SAOK, '0, 4'b0100, 4'b0100, 0);
      chk("prio_hold", 64'(stage_data[W*2 +: W]), 64'h000B);
      chk("prio_hv", 64'(stage_valid[2]), 64'(1));
      drv(0, SAOK, '0, '0, 4'b0100, 0);
      chk("prio_bub", 64'(stage_data[W*2 +: W]), 64'(BV));
      chk("prio_bv", 64'(stage_valid[2]), 64'(0));

      // randomized rounds
      for (int r = 0; r < 3; r++) begin
         do_reset();
         repeat (150) begin
            bit v;
            logic [1:0] s;
            logic [S-1:0] stl, bub;
            v = ($urandom % 4) != 0;
            s = ($urandom % 25 == 0) ? 2'($urandom % 4) : SAOK;
            for (int b = 0; b < S; b++) begin
               stl[b] = ($urandom % 8) == 0;
               bub[b] = ($urandom % 10) == 0;
            end
            drv(v, s, W'($urandom), stl, bub, ($urandom % 40) == 0);
         end
      end

      // halt on SADR retire
      do_reset();
      drv(1, SAOK, 16'h0001, '0, '0, 0);
      drv(1, SADR, 16'h0002, '0, '0, 0);
      drv(1, SAOK, 16'h0003, '0, '0, 0);
      idle(1);
      chk("halt_o1", 64'(out_data), 64'(1));
      idle(1);
      chk("halt_pre", 64'(halted), 64'(0));
      chk("halt_ostat", 64'(out_stat), 64'(SADR));
      idle(1);
      chk("halt_h", 64'(halted), 64'(1));
      chk("halt_hs", 64'(halt_stat), 64'(SADR));
      chk("halt_od", 64'(out_data), 64'(2));
      repeat (5) drv(1, SAOK, W'($urandom), 4'(
         $urandom), 4'($urandom), 0);
      chk("halt_frz", 64'(stage_data), {16'h0002, 16'h0003, BV, BV});
      chk("halt_fv", 64'(stage_valid), 64'(4'b1100));
      chk("halt_ret", 64'(cnt_retire), 64'(1));

      // async reset mid-cycle while halted
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // saturation and clear
      idle(40);
      chk("sat_cyc", 64'(cnt_cycle), 64'(CMAX));
      chk("sat_bub", 64'(cnt_bubble), 64'(CMAX));
      drv(0, SAOK, '0, '0, '0, 1);
      chk("clr_cyc", 64'(cnt_cycle), 64'(0));
      idle(1);
      chk("clr_inc", 64'(cnt_cycle), 64'(1));

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
